vga_text_writer: RTL

Write-side front end of the VGA text-mode buffer. It accepts a byte stream of character codes over a valid/ready handshake and interprets them as terminal input: printable characters, CR, LF, BS and a clear-screen request. It writes the resulting cells into the text memory through a single write port. Each cell holds one byte at address row*(h_disp/8)+col, the same linear layout the display side scans, so the two sides share one dual-port character RAM.

---
 rtl/vga_text_writer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vga_text_writer.sv
// Terminal-style writer for the VGA text buffer: turns a byte stream into cell writes.
// Optional macro VGA_TEXT_TAB_EN adds horizontal-tab expansion to 8-column stops.
module vga_text_writer #(
  parameter int h_disp          = 1280,
  parameter int v_disp          = 1024,
  parameter int char_addr_width = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_char,
  output logic                       in_ready,
  input  logic                       clear_req,
  output logic [char_addr_width-1:0] addr_write,
  output logic [7:0]                 data_write,
  output logic                       we,
  output logic [15:0]                cursor_x,
  output logic [15:0]                cursor_y
);

  localparam int COLS  = h_disp / 8;
  localparam int ROWS  = v_disp / 8;
  localparam int CELLS = COLS * ROWS;
  localparam int CW    = $clog2(CELLS + 1);

  localparam logic [15:0]   LAST_COL  = 16'(COLS - 1);
  localparam logic [15:0]   LAST_ROW  = 16'(ROWS - 1);
  localparam logic [CW-1:0] COLS_W    = CW'(COLS);
  localparam logic [CW-1:0] LAST_CELL = CW'(CELLS - 1);
  localparam logic [CW-1:0] LAST_LCOL = CW'(COLS - 1);

`ifdef VGA_TEXT_TAB_EN
  typedef enum logic [1:0] {S_IDLE, S_CLEAR_LINE, S_CLEAR_ALL, S_TAB} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CLEAR_LINE, S_CLEAR_ALL} state_t;
`endif

  state_t                     r_state;
  logic [CW-1:0]              r_cnt;
  logic [CW-1:0]              r_row_base;
  logic [15:0]                r_cursor_x;
  logic [15:0]                r_cursor_y;
  logic                       r_we;
  logic [char_addr_width-1:0] r_addr;
  logic [7:0]                 r_data;

  logic [CW-1:0] w_cell_addr;
  logic [15:0]   w_lf_y;
  logic [CW-1:0] w_lf_base;
  logic          w_printable;

  // Line feed targets: next row and its base, both wrapping to row 0.
  assign w_lf_y      = (r_cursor_y == LAST_ROW) ? 16'd0 : r_cursor_y + 16'd1;
  assign w_lf_base   = (r_cursor_y == LAST_ROW) ? {CW{1'b0}} : r_row_base + COLS_W;
  assign w_cell_addr = r_row_base + CW'(r_cursor_x);
  assign w_printable = (in_char >= 8'h20) && (in_char <= 8'h7E);

  assign in_ready   = (r_state == S_IDLE) && !reset;
  assign we         = r_we;
  assign addr_write = r_addr;
  assign data_write = r_data;
  assign cursor_x   = r_cursor_x;
  assign cursor_y   = r_cursor_y;

  // Control FSM with registered write port and cursor.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_CLEAR_ALL;
      r_cnt      <= {CW{1'b0}};
      r_row_base <= {CW{1'b0}};
      r_cursor_x <= 16'd0;
      r_cursor_y <= 16'd0;
      r_we       <= 1'b0;
      r_addr     <= {char_addr_width{1'b0}};
      r_data     <= 8'h20;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state    <= S_CLEAR_ALL;
            r_cnt      <= {CW{1'b0}};
            r_row_base <= {CW{1'b0}};
            r_cursor_x <= 16'd0;
            r_cursor_y <= 16'd0;
          end else if (in_valid) begin
            if (w_printable) begin
              r_we   <= 1'b1;
              r_addr <= char_addr_width'(w_cell_addr);
              r_data <= in_char;
              if (r_cursor_x == LAST_COL) begin
                r_cursor_x <= 16'd0;
                r_cursor_y <= w_lf_y;
                r_row_base <= w_lf_base;
                r_cnt      <= {CW{1'b0}};
                r_state    <= S_CLEAR_LINE;
              end else begin
                r_cursor_x <= r_cursor_x + 16'd1;
              end
            end else if (in_char == 8'h0A) begin
              r_cursor_x <= 16'd0;
              r_cursor_y <= w_lf_y;
              r_row_base <= w_lf_base;
              r_cnt      <= {CW{1'b0}};
              r_state    <= S_CLEAR_LINE;
            end else if (in_char == 8'h0D) begin
              r_cursor_x <= 16'd0;
            end else if (in_char == 8'h08) begin
              if (r_cursor_x != 16'd0) begin
                r_cursor_x <= r_cursor_x - 16'd1;
                r_we       <= 1'b1;
                r_addr     <= char_addr_width'(w_cell_addr - {{(CW-1){1'b0}}, 1'b1});
                r_data     <= 8'h20;
              end else begin
                r_cursor_x <= r_cursor_x;
              end
`ifdef VGA_TEXT_TAB_EN
            end else if (in_char == 8'h09) begin
              r_state <= S_TAB;
`endif
            end else begin
              r_cursor_x <= r_cursor_x;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR_LINE: begin
          r_we   <= 1'b1;
          r_addr <= char_addr_width'(r_row_base + r_cnt);
          r_data <= 8'h20;
          if (r_cnt == LAST_LCOL) begin
            r_cnt   <= {CW{1'b0}};
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_CLEAR_ALL: begin
          r_we   <= 1'b1;
          r_addr <= char_addr_width'(r_cnt);
          r_data <= 8'h20;
          if (r_cnt == LAST_CELL) begin
            r_cnt   <= {CW{1'b0}};
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
`ifdef VGA_TEXT_TAB_EN
        // One space per cycle until the next 8-column stop; last column wraps like a printable.
        S_TAB: begin
          r_we   <= 1'b1;
          r_addr <= char_addr_width'(w_cell_addr);
          r_data <= 8'h20;
          if (r_cursor_x == LAST_COL) begin
            r_cursor_x <= 16'd0;
            r_cursor_y <= w_lf_y;
            r_row_base <= w_lf_base;
            r_cnt      <= {CW{1'b0}};
            r_state    <= S_CLEAR_LINE;
          end else begin
            r_cursor_x <= r_cursor_x + 16'd1;
            if (r_cursor_x[2:0] == 3'd7) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_TAB;
            end
          end
        end
`endif
        default: begin
          r_state    <= S_CLEAR_ALL;
          r_cnt      <= {CW{1'b0}};
          r_row_base <= {CW{1'b0}};
          r_cursor_x <= 16'd0;
          r_cursor_y <= 16'd0;
        end
      endcase
    end
  end

endmodule
